// File: rtl/note_scheduler_pkg.sv
// Shared widths, entry-type encoding and slot payload for the song sequencer,
// the note scheduler and the note players.
package note_scheduler_pkg;

    localparam int unsigned NOTE_W = 6;
    localparam int unsigned DUR_W  = 6;
    localparam int unsigned META_W = 3;

    typedef enum logic {
        ENTRY_NOTE = 1'b0,
        ENTRY_WAIT = 1'b1
    } entry_type_e;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  duration;
        logic [META_W-1:0] meta;
    } slot_data_t;

endpackage

// File: rtl/note_scheduler_voice_slot.sv
// One voice slot: holds note/meta for a beat-counted duration and flags fresh loads.
module voice_slot
    import note_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              tick_i,
    input  slot_data_t        data_i,
    output logic [NOTE_W-1:0] note_o,
    output logic [META_W-1:0] meta_o,
    output logic              active_o,
    output logic              new_o
);

    logic [NOTE_W-1:0] note_q, note_d;
    logic [META_W-1:0] meta_q, meta_d;
    logic [DUR_W-1:0]  cnt_q, cnt_d;
    logic              active_q, active_d;
    logic              new_q, new_d;

    // A load overrides any same-cycle beat; note/meta hold after expiry.
    always_comb begin
        note_d   = note_q;
        meta_d   = meta_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        new_d    = 1'b0;
        if (load_i) begin
            note_d   = data_i.note;
            meta_d   = data_i.meta;
            cnt_d    = data_i.duration;
            active_d = 1'b1;
            new_d    = 1'b1;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - DUR_W'(1);
            if (cnt_q == DUR_W'(1)) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            note_q   <= '0;
            meta_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            new_q    <= 1'b0;
        end else begin
            note_q   <= note_d;
            meta_q   <= meta_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            new_q    <= new_d;
        end
    end

    assign note_o   = note_q;
    assign meta_o   = meta_q;
    assign active_o = active_q;
    assign new_o    = new_q;

endmodule

// File: rtl/note_scheduler.sv
// Consumes sequencer entries: allocates note entries to voice slots (with
// round-robin stealing) and runs the wait timer that paces the sequencer.
module note_scheduler
    import note_scheduler_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play,
    input  logic                         beat,
    input  logic                         load_count,
    input  logic                         type_signal,
    input  logic [NOTE_W-1:0]            note,
    input  logic [DUR_W-1:0]             duration,
    input  logic [META_W-1:0]            meta,
    output logic                         advance,
    output logic                         waiting,
    output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
    output logic [META_W*NUM_VOICES-1:0] voice_meta,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES-1:0]        voice_new
);

    localparam int unsigned SP_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic                  tick;
    logic                  note_load;
    logic                  wait_load;
    logic                  found;
    logic [SP_W-1:0]       target;
    logic [NUM_VOICES-1:0] slot_load;
    logic [SP_W-1:0]       steal_q, steal_d;
    logic [DUR_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  waiting_q, waiting_d;
    logic                  advance_q, advance_d;
    slot_data_t            load_data;

    assign tick      = play & beat;
    assign note_load = load_count & (type_signal == ENTRY_NOTE) & (duration != '0);
    assign wait_load = load_count & (type_signal == ENTRY_WAIT);
    assign load_data = '{note: note, duration: duration, meta: meta};

    // Lowest free slot on pre-edge flags; otherwise steal and advance the pointer.
    always_comb begin
        slot_load = '0;
        steal_d   = steal_q;
        found     = 1'b0;
        target    = steal_q;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (!found && !voice_active[i]) begin
                found  = 1'b1;
                target = SP_W'(i);
            end
        end
        if (note_load) begin
            slot_load[target] = 1'b1;
            if (!found) begin
                steal_d = (steal_q == SP_W'(NUM_VOICES - 1)) ? '0 : steal_q + SP_W'(1);
            end
        end
    end

    // Wait timer: a zero-length wait pulses advance straight away.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        waiting_d  = waiting_q;
        advance_d  = 1'b0;
        if (wait_load) begin
            wait_cnt_d = duration;
            waiting_d  = (duration != '0);
            advance_d  = (duration == '0);
        end else if (tick && (wait_cnt_q != '0)) begin
            wait_cnt_d = wait_cnt_q - DUR_W'(1);
            if (wait_cnt_q == DUR_W'(1)) begin
                waiting_d = 1'b0;
                advance_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            steal_q    <= '0;
            wait_cnt_q <= '0;
            waiting_q  <= 1'b0;
            advance_q  <= 1'b0;
        end else begin
            steal_q    <= steal_d;
            wait_cnt_q <= wait_cnt_d;
            waiting_q  <= waiting_d;
            advance_q  <= advance_d;
        end
    end

    assign advance = advance_q;
    assign waiting = waiting_q;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
        voice_slot u_slot (
            .clk      (clk),
            .reset    (reset),
            .load_i   (slot_load[g]),
            .tick_i   (tick),
            .data_i   (load_data),
            .note_o   (voice_note[g*NOTE_W +: NOTE_W]),
            .meta_o   (voice_meta[g*META_W +: META_W]),
            .active_o (voice_active[g]),
            .new_o    (voice_new[g])
        );
    end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed scenarios plus randomized traffic checked against a beat-level
// behavioural model of the note scheduler.
module tb_note_scheduler;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           play = 1'b0;
    logic           beat = 1'b0;
    logic           load_count = 1'b0;
    logic           type_signal = 1'b0;
    logic [5:0]     note = '0;
    logic [5:0]     duration = '0;
    logic [2:0]     meta = '0;
    logic           advance;
    logic           waiting;
    logic [6*N-1:0] voice_note;
    logic [3*N-1:0] voice_meta;
    logic [N-1:0]   voice_active;
    logic [N-1:0]   voice_new;

    int vecs = 0;
    int errs = 0;

    // Model state: remaining beats per slot (active == count>0), held note/meta.
    int       m_cnt[N];
    int       m_note[N];
    int       m_meta[N];
    bit       m_new[N];
    int       m_steal;
    int       m_wait;
    bit       m_adv;

    note_scheduler #(.NUM_VOICES(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .beat         (beat),
        .load_count   (load_count),
        .type_signal  (type_signal),
        .note         (note),
        .duration     (duration),
        .meta         (meta),
        .advance      (advance),
        .waiting      (waiting),
        .voice_note   (voice_note),
        .voice_meta   (voice_meta),
        .voice_active (voice_active),
        .voice_new    (voice_new)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit rst, input bit ld, input bit typ, input int n,
                              input int d, input int m, input bit bt, input bit pl);
        int tgt;
        bit tick;
        tick  = bt && pl;
        tgt   = -1;
        m_adv = 1'b0;
        for (int i = 0; i < N; i++) m_new[i] = 1'b0;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0; m_note[i] = 0; m_meta[i] = 0;
            end
            m_steal = 0;
            m_wait  = 0;
            return;
        end
        if (ld && !typ && d != 0) begin
            for (int i = 0; i < N; i++) if (tgt < 0 && m_cnt[i] == 0) tgt = i;
            if (tgt < 0) begin
                tgt     = m_steal;
                m_steal = (m_steal + 1) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i == tgt) begin
                m_note[i] = n; m_meta[i] = m; m_cnt[i] = d; m_new[i] = 1'b1;
            end else if (tick && m_cnt[i] > 0) begin
                m_cnt[i]--;
            end
        end
        if (ld && typ) begin
            m_wait = d;
            m_adv  = (d == 0);
        end else if (tick && m_wait > 0) begin
            m_wait--;
            m_adv = (m_wait == 0);
        end
    endtask

    // Drive one clock of inputs; outputs are sampled 1 ns after the edge.
    task automatic cycle(input bit rst, input bit ld, input bit typ, input int n,
                         input int d, input int m, input bit bt, input bit pl);
        reset = rst; load_count = ld; type_signal = typ;
        note = 6'(n); duration = 6'(d); meta = 3'(m); beat = bt; play = pl;
        @(posedge clk);
        model_step(rst, ld, typ, n, d, m, bt, pl);
        #1;
    endtask

    task automatic idle(input bit bt, input bit pl);
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, bt, pl);
    endtask

    task automatic test_reset;
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        vecs++;
        if ({advance, waiting, voice_note, voice_meta, voice_active, voice_new} !== '0) begin
            errs++;
            $display("FAIL reset_outputs got note=%h act=%b adv=%b wait=%b want all zero",
                     voice_note, voice_active, advance, waiting);
        end
    endtask

    task automatic test_note_basic;
        cycle(1'b0, 1'b1, 1'b0, 20, 3, 5, 1'b0, 1'b1);
        vecs++;
        if (voice_active !== 3'b001 || voice_new !== 3'b001 || voice_note[5:0] !== 6'd20
            || voice_meta[2:0] !== 3'd5) begin
            errs++;
            $display("FAIL note_load got act=%b new=%b note0=%0d meta0=%0d want 001 001 20 5",
                     voice_active, voice_new, voice_note[5:0], voice_meta[2:0]);
        end
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        vecs++;
        if (voice_new !== 3'b000 || voice_active !== 3'b001) begin
            errs++;
            $display("FAIL note_hold got new=%b act=%b want 000 001", voice_new, voice_active);
        end
        idle(1'b1, 1'b1);
        vecs++;
        if (voice_active !== 3'b000 || voice_note[5:0] !== 6'd20) begin
            errs++;
            $display("FAIL note_expire got act=%b note0=%0d want 000 20",
                     voice_active, voice_note[5:0]);
        end
    endtask

    task automatic test_wait;
        test_reset();
        cycle(1'b0, 1'b1, 1'b1, 0, 2, 0, 1'b0, 1'b1);
        vecs++;
        if (waiting !== 1'b1 || advance !== 1'b0) begin
            errs++;
            $display("FAIL wait_load got waiting=%b advance=%b want 1 0", waiting, advance);
        end
        idle(1'b1, 1'b1);
        vecs++;
        if (waiting !== 1'b1 || advance !== 1'b0) begin
            errs++;
            $display("FAIL wait_beat1 got waiting=%b advance=%b want 1 0", waiting, advance);
        end
        idle(1'b1, 1'b1);
        vecs++;
        if (waiting !== 1'b0 || advance !== 1'b1) begin
            errs++;
            $display("FAIL wait_expire got waiting=%b advance=%b want 0 1", waiting, advance);
        end
        idle(1'b1, 1'b1);
        vecs++;
        if (advance !== 1'b0) begin
            errs++;
            $display("FAIL advance_one_cycle got advance=%b want 0", advance);
        end
        cycle(1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b1);
        vecs++;
        if (waiting !== 1'b0 || advance !== 1'b1) begin
            errs++;
            $display("FAIL wait_zero got waiting=%b advance=%b want 0 1", waiting, advance);
        end
        idle(1'b0, 1'b1);
        vecs++;
        if (advance !== 1'b0) begin
            errs++;
            $display("FAIL wait_zero_once got advance=%b want 0", advance);
        end
    endtask

    task automatic test_steal;
        test_reset();
        for (int k = 1; k <= 3; k++) cycle(1'b0, 1'b1, 1'b0, k, 10, k, 1'b0, 1'b1);
        vecs++;
        if (voice_active !== 3'b111 || voice_note !== {6'd3, 6'd2, 6'd1}) begin
            errs++;
            $display("FAIL steal_fill got act=%b notes=%h want 111 %h",
                     voice_active, voice_note, {6'd3, 6'd2, 6'd1});
        end
        cycle(1'b0, 1'b1, 1'b0, 4, 10, 0, 1'b0, 1'b1);
        vecs++;
        if (voice_note[5:0] !== 6'd4 || voice_new !== 3'b001) begin
            errs++;
            $display("FAIL steal_slot0 got note0=%0d new=%b want 4 001", voice_note[5:0], voice_new);
        end
        cycle(1'b0, 1'b1, 1'b0, 5, 10, 0, 1'b0, 1'b1);
        vecs++;
        if (voice_note[11:6] !== 6'd5 || voice_new !== 3'b010) begin
            errs++;
            $display("FAIL steal_slot1 got note1=%0d new=%b want 5 010", voice_note[11:6], voice_new);
        end
    endtask

    task automatic test_play_freeze;
        bit seen_adv;
        test_reset();
        cycle(1'b0, 1'b1, 1'b1, 0, 1, 0, 1'b0, 1'b1);
        seen_adv = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idle(1'b1, 1'b0);
            if (advance || !waiting) seen_adv = 1'b1;
        end
        vecs++;
        if (seen_adv !== 1'b0) begin
            errs++;
            $display("FAIL freeze got early advance/waiting drop=%b want 0", seen_adv);
        end
        idle(1'b1, 1'b1);
        vecs++;
        if (advance !== 1'b1 || waiting !== 1'b0) begin
            errs++;
            $display("FAIL unfreeze got advance=%b waiting=%b want 1 0", advance, waiting);
        end
    endtask

    task automatic test_same_cycle;
        test_reset();
        cycle(1'b0, 1'b1, 1'b0, 7, 1, 1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 8, 10, 2, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 9, 10, 3, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 33, 7, 6, 1'b1, 1'b1);
        vecs++;
        if (voice_active !== 3'b111 || voice_note[5:0] !== 6'd33 || voice_new !== 3'b001) begin
            errs++;
            $display("FAIL load_wins got act=%b note0=%0d new=%b want 111 33 001",
                     voice_active, voice_note[5:0], voice_new);
        end
        for (int k = 0; k < 6; k++) idle(1'b1, 1'b1);
        vecs++;
        if (voice_active !== 3'b111) begin
            errs++;
            $display("FAIL load_undecremented got act=%b want 111", voice_active);
        end
        idle(1'b1, 1'b1);
        vecs++;
        if (voice_active !== 3'b110) begin
            errs++;
            $display("FAIL reload_expire got act=%b want 110", voice_active);
        end
    endtask

    task automatic test_reset_mid;
        bit seen_adv;
        test_reset();
        cycle(1'b0, 1'b1, 1'b1, 0, 3, 0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 12, 5, 4, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        test_reset();
        seen_adv = 1'b0;
        for (int k = 0; k < 6; k++) begin
            idle(1'b1, 1'b1);
            if (advance || waiting || voice_active != '0) seen_adv = 1'b1;
        end
        vecs++;
        if (seen_adv !== 1'b0) begin
            errs++;
            $display("FAIL reset_drop got activity after reset=%b want 0", seen_adv);
        end
    endtask

    task automatic test_random;
        logic [6*N-1:0] e_note;
        logic [3*N-1:0] e_meta;
        logic [N-1:0]   e_act, e_new;
        test_reset();
        for (int c = 0; c < 3000; c++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 63)), int'($urandom_range(0, 6)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0);
            for (int i = 0; i < N; i++) begin
                e_note[i*6 +: 6] = 6'(m_note[i]);
                e_meta[i*3 +: 3] = 3'(m_meta[i]);
                e_act[i]         = (m_cnt[i] > 0);
                e_new[i]         = m_new[i];
            end
            vecs++;
            if (advance !== m_adv || waiting !== (m_wait > 0)) begin
                errs++;
                $display("FAIL rand_wait cyc=%0d got adv=%b wait=%b want %b %b",
                         c, advance, waiting, m_adv, (m_wait > 0));
            end
            vecs++;
            if (voice_active !== e_act || voice_new !== e_new) begin
                errs++;
                $display("FAIL rand_flags cyc=%0d got act=%b new=%b want %b %b",
                         c, voice_active, voice_new, e_act, e_new);
            end
            vecs++;
            if (voice_note !== e_note || voice_meta !== e_meta) begin
                errs++;
                $display("FAIL rand_data cyc=%0d got note=%h meta=%h want %h %h",
                         c, voice_note, voice_meta, e_note, e_meta);
            end
        end
    endtask

    initial begin
        test_reset();
        test_note_basic();
        test_wait();
        test_steal();
        test_play_freeze();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
